// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

    // Returns {valid, idx}: valid when exactly one column is low, idx is its position.
    function automatic logic [2:0] onehot_low_idx(input logic [COLS-1:0] col);
        logic [2:0] res;
        res = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (col == ~(COLS'(1) << i)) begin
                res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs, with a configurable reset value.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture; both stages load RST_VAL on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row strobe, column debounce, one event per press,
// accepted codes shifted into a 32-bit word for the display driver.
module keypad_scan
    import keypad_pkg::state_t, keypad_pkg::SCAN, keypad_pkg::HOLD,
           keypad_pkg::KEY_W, keypad_pkg::onehot_low_idx;
#(
    parameter int CLK_DIV  = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [3:0]       col,
    output logic [3:0]       row,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_code,
    output logic [31:0]      value
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [3:0]       col_s;
    logic [DIV_W-1:0] div;
    logic             tick;
    state_t           state;
    logic [1:0]       row_idx;
    logic [CNT_W-1:0] cnt;
    logic [KEY_W-1:0] cand;
    logic             key_ok;
    logic [1:0]       col_idx;
    logic             accept;

    sync_2ff #(
        .WIDTH   (4),
        .RST_VAL (4'b1111)
    ) u_col_sync (
        .clk (clk),
        .rst (rst),
        .d   (col),
        .q   (col_s)
    );

    // Scan-step divider: wraps after CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst || tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Step strobe, column decode and accept condition.
    // Accept fires the cycle after cnt reaches DEBOUNCE; CLK_DIV >= 2 keeps it off a tick.
    always_comb begin
        tick              = (div == DIV_LAST);
        {key_ok, col_idx} = onehot_low_idx(col_s);
        accept            = (state == keypad_pkg::DEBOUNCE) && (cnt == CNT_FULL);
        row               = ~(4'b0001 << row_idx);
    end

    // Scan / debounce / hold FSM with registered key event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            row_idx   <= '0;
            cnt       <= '0;
            cand      <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            key_valid <= 1'b0;
            if (accept) begin
                key_valid <= 1'b1;
                key_code  <= cand;
                state     <= HOLD;
                cnt       <= '0;
            end else if (tick) begin
                case (state)
                    SCAN: begin
                        if (key_ok) begin
                            cand  <= {row_idx, col_idx};
                            cnt   <= CNT_W'(1);
                            state <= keypad_pkg::DEBOUNCE;
                        end else begin
                            row_idx <= row_idx + 1'b1;
                        end
                    end
                    keypad_pkg::DEBOUNCE: begin
                        if (key_ok && (col_idx == cand[1:0])) begin
                            cnt <= cnt + 1'b1;
                        end else begin
                            state   <= SCAN;
                            row_idx <= row_idx + 1'b1;
                            cnt     <= '0;
                        end
                    end
                    HOLD: begin
                        if (col_s == 4'b1111) begin
                            if (cnt == CNT_LAST) begin
                                state   <= SCAN;
                                row_idx <= row_idx + 1'b1;
                                cnt     <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                    default: begin
                        state <= SCAN;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Code shift register; clr wipes history but keeps a same-cycle accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (accept) begin
            value <= clr ? {28'b0, cand} : {value[27:0], cand};
        end else if (clr) begin
            value <= '0;
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: physical keypad model drives col from row,
// a cycle model predicts outputs, plus literal checks of key scenarios.
module tb_keypad_scan;

    localparam int CLK_DIV = 4;
    localparam int DEB     = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] value;

    logic [3:0]  prs [4];   // pressed keys: prs[row][col]
    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    keypad_scan #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .col       (col),
        .row       (row),
        .key_valid (key_valid),
        .key_code  (key_code),
        .value     (value)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) col = col & ~prs[r];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 scanning, 1 confirming press, 2 waiting for release.
    int          m_phase, m_mode, m_cnt, m_rix, m_cr, m_cc;
    logic [3:0]  m_s1, m_s2, m_code;
    logic        m_kv;
    logic [31:0] m_val;
    bit          started = 0;

    always @(posedge clk) begin
        automatic logic [3:0] seen = ~prs[m_rix];
        automatic logic       single = ($countones(~m_s2) == 1);
        automatic int         zi = 0;
        automatic logic [3:0] code = 4'(m_cr * 4 + m_cc);
        for (int i = 0; i < 4; i++) if (!m_s2[i]) zi = i;
        started <= 1'b1;
        if (rst) begin
            m_phase <= 0; m_mode <= 0; m_cnt <= 0; m_rix <= 0; m_cr <= 0; m_cc <= 0;
            m_s1 <= 4'hF; m_s2 <= 4'hF; m_kv <= 1'b0; m_code <= 4'h0; m_val <= 32'h0;
        end else begin
            m_kv <= 1'b0;
            if (m_mode == 1 && m_cnt == DEB) begin
                m_kv   <= 1'b1;
                m_code <= code;
                m_val  <= clr ? {28'h0, code} : {m_val[27:0], code};
                m_mode <= 2;
                m_cnt  <= 0;
            end else begin
                if (clr) m_val <= 32'h0;
                if (m_phase == CLK_DIV - 1) begin
                    if (m_mode == 0) begin
                        if (single) begin
                            m_cr <= m_rix; m_cc <= zi; m_cnt <= 1; m_mode <= 1;
                        end else m_rix <= (m_rix + 1) % 4;
                    end else if (m_mode == 1) begin
                        if (single && zi == m_cc) m_cnt <= m_cnt + 1;
                        else begin m_mode <= 0; m_rix <= (m_rix + 1) % 4; m_cnt <= 0; end
                    end else begin
                        if (m_s2 == 4'hF) begin
                            if (m_cnt + 1 == DEB) begin
                                m_mode <= 0; m_rix <= (m_rix + 1) % 4; m_cnt <= 0;
                            end else m_cnt <= m_cnt + 1;
                        end else m_cnt <= 0;
                    end
                end
            end
            m_s1    <= seen;
            m_s2    <= m_s1;
            m_phase <= (m_phase + 1) % CLK_DIV;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            automatic logic [3:0] er = ~(4'(1) << m_rix);
            chk("row", row, er);
            chk("key_valid", key_valid, m_kv);
            chk("key_code", key_code, m_code);
            chk("value", value, m_val);
            if (key_valid === 1'b1) pulses++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic press_key(input int r, input int c);
        prs[r][c] = 1'b1;
        step(60);
        prs[r] = 4'b0000;
        step(40);
    endtask

    initial begin
        automatic logic [3:0] exp_rows [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        automatic int k, n, p0, changes;
        automatic logic found;
        automatic logic [3:0] prev;
        for (int r = 0; r < 4; r++) prs[r] = 4'b0000;

        // Idle scan sequence after reset.
        do_reset();
        p0 = pulses;
        for (int i = 0; i < 20; i++) begin
            chk("scan_row", row, exp_rows[(i / 4) % 4]);
            step(1);
        end
        chk("idle_pulses", pulses - p0, 0);
        chk("idle_value", value, 32'h0);

        // Key 9 (row 2, col 1): detected at edge 12, pulse 9 clk later.
        do_reset();
        prs[2] = 4'b0010;
        p0 = pulses; k = 0; found = 1'b0;
        while (!found && k < 40) begin
            step(1);
            k++;
            if (key_valid === 1'b1) found = 1'b1;
        end
        chk("press_latency", k, 21);
        step(40 - k);
        prs[2] = 4'b0000;
        step(40);
        chk("k9_pulses", pulses - p0, 1);
        chk("k9_code", key_code, 4'h9);
        chk("k9_value", value, 32'h9);

        // Sequence 1, 2, A, F after a clear.
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_value", value, 32'h0);
        p0 = pulses;
        press_key(0, 1);
        press_key(0, 2);
        press_key(2, 2);
        press_key(3, 3);
        chk("seq_value", value, 32'h12AF);
        chk("seq_model", m_val, 32'h12AF);
        chk("seq_pulses", pulses - p0, 4);

        // Bouncing key 7: alternate each step for five steps, then stable.
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            prs[1] = (i % 2 == 0) ? 4'b1000 : 4'b0000;
            step(CLK_DIV);
        end
        chk("bounce_pulses", pulses - p0, 0);
        prs[1] = 4'b1000;
        step(60);
        chk("bounce_accept", pulses - p0, 1);
        chk("bounce_code", key_code, 4'h7);
        prs[1] = 4'b0000;
        step(40);

        // Two columns on row 2: ignored, scanning continues; then single key 9.
        p0 = pulses;
        prs[2] = 4'b0011;
        prev = row; changes = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (row != prev) changes++;
            prev = row;
        end
        chk("twocol_pulses", pulses - p0, 0);
        chk("twocol_scanning", 32'(changes >= 8), 1);
        prs[2] = 4'b0010;
        step(60);
        chk("twocol_accept", pulses - p0, 1);
        chk("twocol_code", key_code, 4'h9);
        prs[2] = 4'b0000;
        step(40);

        // clr coinciding with the accept of key 5 on top of 1234.
        do_reset();
        press_key(0, 1);
        press_key(0, 2);
        press_key(0, 3);
        press_key(1, 0);
        chk("v1234", value, 32'h1234);
        prs[1] = 4'b0010;
        n = 0;
        while (!(m_mode == 1 && m_cnt == DEB) && n < 200) begin
            step(1);
            n++;
        end
        chk("clr_accept_wait", 32'(n < 200), 1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_accept_value", value, 32'h5);
        chk("clr_accept_code", key_code, 4'h5);

        // Reset during hold; held key is then re-detected.
        step(8);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("rst_row", row, 4'b1110);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_code", key_code, 4'h0);
        chk("rst_value", value, 32'h0);
        p0 = pulses;
        step(60);
        chk("redetect_pulses", pulses - p0, 1);
        chk("redetect_code", key_code, 4'h5);
        chk("redetect_value", value, 32'h5);
        prs[1] = 4'b0000;
        step(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix-keypad scanner for the board's 4x4 hex keypad: the input-side counterpart of the multiplexed display driver. It strobes one row at a time, reads the columns, debounces, and emits one event per key press. Each accepted key's hex code is shifted into a 32-bit word so that word can feed the display driver directly.

## Interface
- CLK_DIV, 50000: clk cycles per scan step; must be ≥ 2.
- DEBOUNCE, 4: consecutive matching step samples required to accept a press or a release; must be ≥ 1.
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- clr  input  1  synchronous clear of `value`.
- col  input  4  keypad columns, active-low, pulled up, asynchronous.
- row  output  4  row drive, active-low, exactly one bit low at any time.
- key_valid  output  1  one-cycle pulse per accepted press.
- key_code  output  4  code of the last accepted key; `row_idx*4 + col_idx`.
- value  output  32  shift register of accepted codes; newest code in [3:0].

## Operation
- `col` passes through a 2-flop synchronizer. All decisions use the synchronized value `col_s`.
- Divider counter `div` counts 0..CLK_DIV-1 and wraps. `tick` is asserted when `div == CLK_DIV-1`. All sampling happens only on `tick`.
- `row = ~(4'b0001 << row_idx)`, where `row_idx` is 2 bits.
- A sample is a valid key when `col_s` has exactly one bit low. `col_idx` is the position of that bit.
- SCAN state:
  - On `tick`, a valid key captures `row_idx` and `col_idx` into `cand`, sets `cnt = 1`, and moves to DEBOUNCE. If DEBOUNCE == 1, it goes directly to the accept step instead.
  - Otherwise `row_idx` increments, wrapping 3 -> 0.
  - Any `col_s` pattern other than exactly-one-low counts as no key. This includes multiple keys pressed.
- DEBOUNCE state:
  - `row_idx` is frozen.
  - On `tick`, a valid key with `col_idx == cand.col` increments `cnt`.
  - Any other sample returns to SCAN with `row_idx+1` and `cnt = 0`.
- Accept step:
  - Taken when `cnt` reaches DEBOUNCE.
  - On the next clk, `key_valid = 1`, `key_code = cand`, and `value = {value[27:0], cand}`.
  - Moves to HOLD with `cnt = 0`.
- HOLD state:
  - `row_idx` is frozen.
  - On `tick`, `col_s == 4'b1111` increments `cnt`. Any other sample resets `cnt` to 0.
  - At `cnt == DEBOUNCE`, returns to SCAN with `row_idx+1` and `cnt = 0`.
  - No new press is reported until release is confirmed, so there is no auto-repeat.
- `clr`:
  - `value` becomes 0 the next cycle.
  - If it coincides with an accept, `value = {28'b0, cand}`.
  - State, `key_code` and `row` are unaffected.
- `rst` applies from any state, including mid-debounce or mid-hold. On reset:
  - `state = SCAN`, `row_idx = 0` (`row = 4'b1110`).
  - `div = 0`, `cnt = 0`.
  - `key_valid = 0`, `key_code = 0`, `value = 0`.
  - Synchronizer flops = `4'b1111`.
  - A press in progress during reset is discarded.
- Widths:
  - `cnt` is `$clog2(DEBOUNCE+1)` bits.
  - `div` is `$clog2(CLK_DIV)` bits.
  - No arithmetic overflow is possible: `cnt` is bounded at DEBOUNCE.

## Timing
- A `col` change becomes visible in `col_s` 2 cycles later.
- `row` changes one cycle after the `tick` that advances it. It then holds a full CLK_DIV cycles before the next sample, which provides the settle time.
- Press latency: for a key held from before the tick that first detects it, `key_valid` rises 1 clk after the tick at which `cnt` reaches DEBOUNCE. That is (DEBOUNCE-1)*CLK_DIV + 1 cycles after the detection tick.
- `key_valid` is high for exactly 1 cycle. `key_code` and `value` update in that same cycle and hold until the next accept (or `clr`, for `value`).
- Release latency is DEBOUNCE ticks of all-high `col_s`. Scanning resumes 1 cycle after the final tick.
- Worst-case detection delay is 4 ticks: one full row sweep.

## Structure
- Shared package `keypad_pkg` contains:
  - state enum `{SCAN, DEBOUNCE, HOLD}`;
  - `KEY_W = 4`, `ROWS = 4`, `COLS = 4`;
  - function `onehot_low_idx(col) -> {valid, idx}`.
- Sub-module `sync_2ff`: a parameterized-width 2-flop synchronizer with a reset value parameter. It is reused for other asynchronous board inputs.
- Everything else lives in one module: divider, FSM, capture/shift register.

## Test plan
Bench parameters: CLK_DIV=4, DEBOUNCE=3.

- Reset, no keys pressed -> `row` cycles 1110, 1101, 1011, 0111, 1110, changing every 4 clk; `key_valid` stays 0; `value = 0`.
- Press row 2, col 1 (`col = 1101` while `row = 1011`), hold 40 cycles, then release -> exactly one `key_valid` pulse, `key_code = 4'h9`, `value = 32'h9`; the pulse occurs 9 clk after the detection tick.
- Press the sequence keys 1, 2, A, F, each with a full release -> `value = 32'h12AF`; exactly 4 pulses.
- Bouncing press (col toggles on alternate ticks for 5 ticks, then stable) -> no pulse during the bounce; exactly one pulse after 3 stable ticks.
- Two columns low at once (`col = 1100`) -> no pulse and scanning continues; releasing one column leaves a single key, which is then accepted normally.
- `clr` in the same cycle as an accept of key 5, with `value = 32'h1234` -> `value = 32'h5`. `rst` asserted during HOLD -> outputs return to reset values and `row = 1110`; a still-held key is re-detected as a new press.
